// File: rtl/event_enc_pkg.sv
// Shared types and helpers for the event encoder.
// Used by prio_enc and event_encoder.
package event_enc_pkg;

    localparam int N_DEF = 4;
    localparam int MAX_W = 256;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [MAX_W-1:0] idx_to_onehot(
        input logic [7:0] idx
    );
        logic [MAX_W-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/event_encoder_prio_enc.sv
// Combinational priority encoder with a rotating search base.
// The lowest offset from base wins; base=0 gives plain lowest-index priority.
module prio_enc
    import event_enc_pkg::*;
#(
    parameter  int N = N_DEF,
    localparam int W = 2**N
) (
    input  logic [W-1:0] req,
    input  logic [N-1:0] base,
    output logic [N-1:0] idx,
    output logic         found
);

    logic [N-1:0] w_pos;

    // Scan from the far end so the smallest offset is the last to win.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        w_pos = '0;
        for (int k = W - 1; k >= 0; k--) begin
            w_pos = base + N'(k);
            if (req[w_pos]) begin
                idx   = w_pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/event_encoder.sv
// Sticky event collector that presents pending events as binary codes.
// Define EVENT_ENCODER_ROUND_ROBIN_EN for rotating selection priority.
module event_encoder
    import event_enc_pkg::*;
#(
    parameter  int N = N_DEF,
    localparam int W = 2**N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] ev_lines,
    output logic [N-1:0] code_out,
    output logic         code_valid,
    input  logic         code_ready,
    output logic [W-1:0] pend_out,
    output logic         overflow,
    input  logic         clr_ovf
);

    state_t       r_state;
    state_t       w_state_n;
    logic [W-1:0] r_pend;
    logic [N-1:0] r_code;
    logic         r_valid;
    logic         r_ovf;

    logic         w_hs;
    logic [W-1:0] w_clr_mask;
    logic [W-1:0] w_next;
    logic         w_ovf_set;
    logic [N-1:0] w_base;
    logic [N-1:0] w_idx;
    logic         w_found;
    logic [N-1:0] w_code_n;
    logic         w_valid_n;

    assign w_hs       = r_valid & code_ready;
    assign w_clr_mask = w_hs ? W'(idx_to_onehot(8'(r_code))) : '0;
    assign w_next     = r_pend & ~w_clr_mask;
    assign w_ovf_set  = |(ev_lines & w_next);

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    logic [N-1:0] r_ptr;

    // On acceptance the search already starts past the accepted index.
    assign w_base = w_hs ? (r_code + N'(1)) : r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= r_code + N'(1);
        end
    end
`else
    assign w_base = '0;
`endif

    prio_enc #(
        .N(N)
    ) u_prio (
        .req  (w_next),
        .base (w_base),
        .idx  (w_idx),
        .found(w_found)
    );

    always_comb begin
        w_state_n = r_state;
        w_code_n  = r_code;
        w_valid_n = r_valid;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_code_n  = w_idx;
                    w_valid_n = 1'b1;
                    w_state_n = HOLD;
                end else begin
                    w_valid_n = 1'b0;
                end
            end
            HOLD: begin
                if (w_hs) begin
                    if (w_found) begin
                        w_code_n = w_idx;
                    end else begin
                        w_valid_n = 1'b0;
                        w_state_n = IDLE;
                    end
                end
            end
            default: begin
                w_valid_n = 1'b0;
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pend  <= w_next | ev_lines;
            r_code  <= w_code_n;
            r_valid <= w_valid_n;
            r_ovf   <= w_ovf_set | (r_ovf & ~clr_ovf);
        end
    end

    assign code_out   = r_code;
    assign code_valid = r_valid;
    assign pend_out   = r_pend;
    assign overflow   = r_ovf;

endmodule
